// File: rtl/tinytester_seqgen.sv
// Vector sequencer: a Wishbone-fed vector FIFO drives the pads across NPHASES
// programmable-length phases; synchronised pad inputs land in a result FIFO.
module tinytester_seqgen #(
  parameter int          NPINS          = 19,
  parameter int          NPHASES        = 4,
  parameter int          FIFO_AW        = 4,
  parameter int          ADDRWIDTH      = 5,
  parameter logic [31:0] DEF_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [31:0]          WBs_DAT_i,
  output logic [31:0]          WBs_DAT_o,
  output logic                 WBs_ACK_o,
  output logic                 interrupt_o,
  output logic [NPINS-1:0]     padout_o,
  output logic [NPINS-1:0]     padoe_o,
  input  logic [NPINS-1:0]     padin_i,
  output logic [NPHASES-1:0]   phase_o
);

  localparam int              PW       = (NPHASES > 1) ? $clog2(NPHASES) : 1;
  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [PW-1:0]   LAST_PH  = PW'(NPHASES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PHASE   = 3'd2,
    S_CAPTURE = 3'd3
  } state_t;

  // Byte strobes are ignored; every access is a full word.
  logic unused_bits;
  assign unused_bits = ^{WBs_BYTE_STB_i, WBs_DAT_i};

  logic ack_q;
  logic wb_req, wr_en, rd_en;
  assign wb_req = WBs_CYC_i & WBs_STB_i;
  assign wr_en  = ack_q & wb_req & WBs_WE_i;
  assign rd_en  = ack_q & wb_req & ~WBs_WE_i;

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) ack_q <= 1'b0;
    else           ack_q <= wb_req & ~ack_q;
  end

  logic          sel_ctrl, sel_status, sel_plen, sel_oe, sel_vpush, sel_rpop, sel_irq, sel_act;
  logic [PW-1:0] act_idx;
  assign sel_ctrl   = (WBs_ADR_i == ADDRWIDTH'(0));
  assign sel_status = (WBs_ADR_i == ADDRWIDTH'(1));
  assign sel_plen   = (WBs_ADR_i == ADDRWIDTH'(2));
  assign sel_oe     = (WBs_ADR_i == ADDRWIDTH'(3));
  assign sel_vpush  = (WBs_ADR_i == ADDRWIDTH'(4));
  assign sel_rpop   = (WBs_ADR_i == ADDRWIDTH'(5));
  assign sel_irq    = (WBs_ADR_i == ADDRWIDTH'(6));
  assign sel_act    = (WBs_ADR_i >= ADDRWIDTH'(8)) && (WBs_ADR_i < ADDRWIDTH'(8 + NPHASES));
  assign act_idx    = PW'(WBs_ADR_i - ADDRWIDTH'(8));

  logic             run_q, en_done_q, en_err_q;
  logic [15:0]      phase_len_q;
  logic [NPINS-1:0] oe_q;
  logic [NPINS-1:0] active_q [NPHASES];
  logic             flush;
  assign flush = wr_en & sel_ctrl & WBs_DAT_i[1];

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      run_q       <= 1'b0;
      en_done_q   <= 1'b0;
      en_err_q    <= 1'b0;
      phase_len_q <= '0;
      oe_q        <= '0;
      for (int p = 0; p < NPHASES; p++) active_q[p] <= '0;
    end else if (wr_en) begin
      if (sel_ctrl) begin
        run_q     <= WBs_DAT_i[0];
        en_done_q <= WBs_DAT_i[2];
        en_err_q  <= WBs_DAT_i[3];
      end
      if (sel_plen) phase_len_q <= WBs_DAT_i[15:0];
      if (sel_oe)   oe_q <= WBs_DAT_i[NPINS-1:0];
      if (sel_act)  active_q[act_idx] <= WBs_DAT_i[NPINS-1:0];
    end
  end

  state_t state_q, state_d;

  // Vector FIFO: extra pointer bit separates full from empty.
  logic [NPINS-1:0] vec_mem [DEPTH];
  logic [FIFO_AW:0] vec_wp_q, vec_rp_q, vec_lvl;
  logic             vec_full, vec_empty, vec_push_req, vec_push, vec_pop, vec_ovf_set;
  assign vec_lvl      = vec_wp_q - vec_rp_q;
  assign vec_full     = (vec_lvl == FULL_LVL);
  assign vec_empty    = (vec_lvl == '0);
  assign vec_push_req = wr_en & sel_vpush;
  assign vec_push     = vec_push_req & ~vec_full;
  assign vec_ovf_set  = vec_push_req & vec_full;
  assign vec_pop      = (state_q == S_LOAD);

  always_ff @(posedge WBs_CLK_i) begin
    if (vec_push) vec_mem[vec_wp_q[FIFO_AW-1:0]] <= WBs_DAT_i[NPINS-1:0];
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i || flush) begin
      vec_wp_q <= '0;
      vec_rp_q <= '0;
    end else begin
      if (vec_push) vec_wp_q <= vec_wp_q + 1'b1;
      if (vec_pop)  vec_rp_q <= vec_rp_q + 1'b1;
    end
  end

  logic [NPINS-1:0] padin_s1_q, padin_s2_q;
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      padin_s1_q <= '0;
      padin_s2_q <= '0;
    end else begin
      padin_s1_q <= padin_i;
      padin_s2_q <= padin_s1_q;
    end
  end

  logic [NPINS-1:0] res_mem [DEPTH];
  logic [FIFO_AW:0] res_wp_q, res_rp_q, res_lvl;
  logic             res_full, res_empty, res_push, res_pop_req, res_pop, res_unf_set;
  assign res_lvl     = res_wp_q - res_rp_q;
  assign res_full    = (res_lvl == FULL_LVL);
  assign res_empty   = (res_lvl == '0);
  assign res_push    = (state_q == S_CAPTURE) & ~res_full;
  assign res_pop_req = rd_en & sel_rpop;
  assign res_pop     = res_pop_req & ~res_empty;
  assign res_unf_set = res_pop_req & res_empty;

  always_ff @(posedge WBs_CLK_i) begin
    if (res_push) res_mem[res_wp_q[FIFO_AW-1:0]] <= padin_s2_q;
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i || flush) begin
      res_wp_q <= '0;
      res_rp_q <= '0;
    end else begin
      if (res_push) res_wp_q <= res_wp_q + 1'b1;
      if (res_pop)  res_rp_q <= res_rp_q + 1'b1;
    end
  end

  logic [PW-1:0]      phase_q, phase_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NPINS-1:0]   cur_q, cur_d, padout_q, padout_d;
  logic [NPHASES-1:0] phase_oh_q, phase_oh_d;
  logic               done_set;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: if (run_q && !vec_empty) state_d = S_LOAD;
      S_LOAD: begin
        cur_d   = vec_mem[vec_rp_q[FIFO_AW-1:0]];
        phase_d = '0;
        cnt_d   = phase_len_q;
        state_d = S_PHASE;
      end
      S_PHASE: begin
        if (cnt_q == 16'd0) begin
          cnt_d = phase_len_q;
          if (phase_q == LAST_PH) state_d = S_CAPTURE;
          else                    phase_d = phase_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CAPTURE: begin
        if (!res_full) begin
          if (run_q && !vec_empty) begin
            state_d = S_LOAD;
          end else begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      done_set = 1'b0;
    end
    // Pad outputs are registered from the next state so they line up with state_q.
    padout_d   = '0;
    phase_oh_d = '0;
    case (state_d)
      S_PHASE: begin
        padout_d   = cur_d & active_q[phase_d];
        phase_oh_d = NPHASES'(1) << phase_d;
      end
      S_CAPTURE: padout_d = padout_q;
      default:   padout_d = '0;
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      cnt_q      <= '0;
      cur_q      <= '0;
      padout_q   <= '0;
      phase_oh_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      padout_q   <= padout_d;
      phase_oh_q <= phase_oh_d;
    end
  end

  // Set events take priority over a W1C landing on the same bit.
  logic [2:0] irq_q, irq_d, irq_w1c;
  logic       intr_q;
  assign irq_w1c = (wr_en && sel_irq) ? WBs_DAT_i[2:0] : 3'b000;
  assign irq_d   = (irq_q & ~irq_w1c) | {res_unf_set, vec_ovf_set, done_set};

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      irq_q  <= '0;
      intr_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      intr_q <= (irq_q[0] & en_done_q) | ((irq_q[1] | irq_q[2]) & en_err_q);
    end
  end

  logic        stalled;
  logic [31:0] rdata;
  assign stalled = (state_q == S_CAPTURE) & res_full;

  always_comb begin
    rdata = '0;
    if (sel_ctrl) begin
      rdata[3:0] = {en_err_q, en_done_q, 1'b0, run_q};
    end else if (sel_status) begin
      rdata[2:0]             = state_q;
      rdata[8 +: FIFO_AW+1]  = vec_lvl;
      rdata[16 +: FIFO_AW+1] = res_lvl;
      rdata[24]              = stalled;
    end else if (sel_plen) begin
      rdata[15:0] = phase_len_q;
    end else if (sel_oe) begin
      rdata[NPINS-1:0] = oe_q;
    end else if (sel_vpush) begin
      rdata = '0;
    end else if (sel_rpop) begin
      if (res_empty) rdata = DEF_READ_VALUE;
      else           rdata[NPINS-1:0] = res_mem[res_rp_q[FIFO_AW-1:0]];
    end else if (sel_irq) begin
      rdata[2:0] = irq_q;
    end else if (sel_act) begin
      rdata[NPINS-1:0] = active_q[act_idx];
    end else begin
      rdata = DEF_READ_VALUE;
    end
  end

  assign WBs_DAT_o   = ack_q ? rdata : '0;
  assign WBs_ACK_o   = ack_q;
  assign interrupt_o = intr_q;
  assign padout_o    = padout_q;
  assign padoe_o     = oe_q;
  assign phase_o     = phase_oh_q;

endmodule

// File: doc/tinytester_seqgen.md
# tinytester_seqgen

Parametrised, FIFO-fed successor to the fixed 32-pin, 4-phase tinytester sequencer. Per-vector drive data is queued over Wishbone into a vector FIFO. Each vector is applied across NPHASES programmable-length phases with a per-phase pin activity mask. The synchronised pad inputs are captured into a result FIFO at the end of each vector. The block sits behind the FPGA register chip-select in the AL4S3B fabric and drives the bidirectional pad muxes directly.

## Interface
- NPINS, 19: pins driven/sampled (1..32)
- NPHASES, 4: phases per vector (2..8)
- FIFO_AW, 4: log2 depth of the vector and result FIFOs (each 2^FIFO_AW entries)
- ADDRWIDTH, 5: Wishbone word-address width
- DEF_READ_VALUE, 32'hBAD_FAB_AC: value returned for undefined addresses and for an empty-FIFO pop

- WBs_CLK_i, in, 1: single clock
- WBs_RST_i, in, 1: synchronous, active-high reset
- WBs_ADR_i, in, ADDRWIDTH: word address
- WBs_CYC_i / WBs_STB_i / WBs_WE_i, in, 1: Wishbone cycle / strobe / write
- WBs_BYTE_STB_i, in, 4: ignored; all accesses are full-word
- WBs_DAT_i, in, 32: write data
- WBs_DAT_o, out, 32: read data, valid while WBs_ACK_o is high
- WBs_ACK_o, out, 1: one-cycle acknowledge
- interrupt_o, out, 1: OR of (IRQ_STATUS & IRQ_EN)
- padout_o, out, NPINS: pad drive value
- padoe_o, out, NPINS: pad output enable
- padin_i, in, NPINS: asynchronous pad inputs
- phase_o, out, NPHASES: one-hot current phase; all zero outside PHASE

## Operation
- Register map (word address):
  - 0 CONTROL (rw): bit0 RUN; bit1 FLUSH (self-clearing); bit2 IRQ_EN_DONE; bit3 IRQ_EN_ERR.
  - 1 STATUS (ro): [2:0] FSM state; [15:8] vector FIFO level; [23:16] result FIFO level; bit24 stalled.
  - 2 PHASE_LEN (rw, 16 bits): cycles per phase minus 1.
  - 3 OE (rw, NPINS bits).
  - 4 VEC_PUSH (wo): pushes WBs_DAT_i[NPINS-1:0].
  - 5 RES_POP (ro): pops the oldest result.
  - 6 IRQ_STATUS (W1C): bit0 DONE; bit1 VEC_OVF; bit2 RES_UNF.
  - 8+p ACTIVE_P[p] (rw, NPINS bits), for p < NPHASES.
  - Any other address reads DEF_READ_VALUE; writes to it are ignored.
- Unused upper data bits read 0.
- FSM states: IDLE, LOAD, PHASE, CAPTURE.
  - IDLE -> LOAD when RUN=1 and the vector FIFO is not empty.
  - LOAD: pop one vector into the cur register, set phase=0, load the phase counter. Always -> PHASE.
  - PHASE: count down PHASE_LEN+1 cycles per phase. At terminal count, phase++; after phase NPHASES-1 -> CAPTURE.
  - CAPTURE: if the result FIFO is full, remain here with stalled=1 and hold the last phase's pad drive; no data is lost. Otherwise push the synchronised padin, then:
    - -> LOAD if RUN=1 and the vector FIFO is not empty;
    - else -> IDLE and set DONE.
- Pad drive:
  - padoe_o = OE at all times.
  - In PHASE, padout_o = cur & ACTIVE_P[phase].
  - In LOAD and IDLE, padout_o = 0.
- padin_i passes through a 2-flop synchroniser before capture.
- Clearing RUN mid-vector: the current vector completes, then the FSM goes to IDLE.
- FLUSH: empties both FIFOs, forces IDLE and padout 0 in the next cycle, and does not set DONE.
- VEC_PUSH when the vector FIFO is full: data dropped, VEC_OVF set. A pop in the same cycle does not make room.
- RES_POP when the result FIFO is empty: returns DEF_READ_VALUE, no pop, RES_UNF set.
- FIFO pointers wrap modulo 2^FIFO_AW. Level width is FIFO_AW+1 and distinguishes full from empty.
- If a W1C write and a set event hit the same IRQ bit in the same cycle, the set wins.
- Reset values:
  - All registers 0; PHASE_LEN = 0.
  - FIFOs empty; FSM in IDLE.
  - padout_o = 0, padoe_o = 0, phase_o = 0.
  - WBs_ACK_o = 0, WBs_DAT_o = 0, interrupt_o = 0.

## Timing
- ACK: asserted the cycle after CYC&STB if ACK was low; one cycle wide. The register write, FIFO push or FIFO pop takes effect on the ACK cycle.
- From the first push (with RUN=1) to padout showing phase 0: 3 cycles (FIFO write, IDLE->LOAD, LOAD->PHASE, registered output).
- Per-vector period: 2 + NPHASES*(PHASE_LEN+1) cycles, back-to-back with no idle gap while vectors are available.
- Captured value: padin as seen 2 cycles before the CAPTURE cycle (synchroniser depth).
- interrupt_o: rises one cycle after the IRQ bit sets. Level output, falls on W1C.

## Test plan
- Basic run:
  - Setup: PHASE_LEN=1, OE=0x7FFFF, ACTIVE_P0..3 = 0x1, 0x2, 0x4, 0x7FFFF; padout looped to padin. Push 0x7FFFF, set RUN.
  - Required: padout sequence 0x1, 0x2, 0x4, 0x7FFFF, each held 2 cycles; RES_POP = 0x7FFFF; DONE set.
- Back-to-back vectors:
  - Stimulus: push 3 vectors, then set RUN.
  - Required: phase_o cycles continuously with a 10-cycle vector period and no IDLE between vectors; 3 results in push order.
- Result FIFO full:
  - Stimulus: FIFO_AW=2; push 5 vectors without popping results.
  - Required: stall in CAPTURE with stalled=1 and pads held. One RES_POP releases the stall; 5 correct results in total.
- Error flags:
  - Stimulus: 17 pushes with RUN=0 at FIFO_AW=4; then a pop on the empty result FIFO.
  - Required: VEC_OVF set with level=16; pop returns 0xBADFABAC and sets RES_UNF. interrupt_o high only when IRQ_EN_ERR=1; W1C clears it.
- Abort:
  - Stimulus: FLUSH mid-PHASE; separately, sync reset mid-PHASE.
  - Required: next cycle is IDLE with padout 0, both FIFO levels 0, DONE not set. After reset, all outputs are at their reset values.
